oh_sequencer: RTL and testbench
===============================

Name: oh_sequencer

Overview:
Registered, parametrised successor to the combinational binary-to-one-hot decoder. Holds a position index that is loaded, stepped up or down with wrap or saturation, and decoded to a registered positional vector, either one-hot or thermometer. Drives ring/scan selects (LED scanners, mux selects) in the lab designs. Flags illegal loads and wrap events.

Parameters:
N, 3, width of binary index.
POS, 2**N, number of positions; legal range 2 .. 2**N, non-power-of-2 allowed.
WRAP, 1, 1 = wrap at the ends; 0 = saturate at the ends.

Ports:
clk  in  1  clock, rising edge.
rst_n  in  1  synchronous active-low reset.
load  in  1  load load_idx this cycle.
load_idx  in  N  binary index to load.
step  in  1  advance one position this cycle.
dir  in  1  0 = up (idx+1), 1 = down (idx-1).
mode  in  1  0 = one-hot, 1 = thermometer.
index  out  N  current position, registered.
positional  out  POS  decoded position, registered.
wrap  out  1  one-cycle pulse: wrap or saturation event occurred.
err  out  1  one-cycle pulse: illegal load rejected.

Behaviour:
- One clock (clk); reset synchronous, active-low (rst_n). All state and outputs are updated on the rising edge of clk only.
- Reset (rst_n=0 at an edge) overrides everything: index=0, positional=1 (bit0 only, in both modes), wrap=0, err=0.
- Reset mid-operation: a pending load or step in the same cycle is discarded.
- Priority when out of reset: load > step. step is ignored in any cycle where load=1.
- Legal load (load_idx < POS): index <= load_idx next edge; err=0.
- Illegal load (load_idx >= POS): index holds; err=1 for one cycle; positional is re-decoded from the held index.
- Step up, index < POS-1: index+1.
- Step up, index = POS-1: WRAP=1 gives 0; WRAP=0 holds POS-1. wrap=1 in both cases.
- Step down, index > 0: index-1.
- Step down, index = 0: WRAP=1 gives POS-1; WRAP=0 holds 0. wrap=1 in both cases.
- Wrap arithmetic is against POS, not 2**N. Index never exceeds POS-1.
- wrap and err are single-cycle pulses and deassert on the next edge unless retriggered. Both are 0 when neither load nor step is active.
- Decode, from the next index and the current mode, registered together with index (latency 1 from the load/step edge):
  - mode=0: positional[i] = (i == index).
  - mode=1: positional[i] = (i <= index).
- A mode change with no load or step re-decodes positional at the next edge; index is unchanged.
- Invariant: index and positional are always mutually consistent in the same cycle. Exactly one bit is set in one-hot mode; index+1 low bits are set in thermometer mode.
- X on the control inputs while rst_n=0 has no effect.

Decomposition:
- Shared package holds:
  - MODE_ONEHOT=1'b0, MODE_THERM=1'b1.
  - DIR_UP=1'b0, DIR_DOWN=1'b1.
  - A function computing the next index given index, dir, POS and WRAP, reused by bench models.
- One natural sub-module: pos_decoder (parameters N, POS). It is a combinational binary-to-positional decoder with a mode input, generalising the existing one-hot decoder.
- oh_sequencer holds the index register, control priority, pulse flags and output register.

Test Plan:
- Reset, then load=1 load_idx=5 (N=3, POS=8, mode=0) -> next edge index=5, positional=8'b0010_0000, err=0, wrap=0.
- From index=7, step=1 dir=0 (WRAP=1) -> index=0, positional=8'b0000_0001, wrap=1 for one cycle. From index=0, dir=1 -> index=7, wrap=1.
- POS=6, WRAP=0, index=5, step up twice -> index stays 5, wrap=1 on both cycles. load_idx=6 -> err=1, index=5. load_idx=7 -> err=1, index=5.
- index=3, mode switched 0->1 with no step -> positional 8'b0000_1000 then 8'b0000_1111 next edge, index=3, no pulses.
- load=1 load_idx=2 together with step=1 dir=0 -> index=2 (load wins). Same with rst_n=0 -> index=0, positional=1.
- Exhaustive sweep: load each idx 0..POS-1 in both modes, compare against the golden decoder. Then step 2*POS cycles up and down, checking a wrap pulse exactly at each boundary crossing.

Source files
------------

// File: rtl/oh_sequencer_pkg.sv
// Shared definitions for the positional sequencer: control encodings and
// the index-stepping rule used by both the sequencer and its models.
package oh_sequencer_pkg;

    localparam logic MODE_ONEHOT = 1'b0;
    localparam logic MODE_THERM  = 1'b1;

    localparam logic DIR_UP   = 1'b0;
    localparam logic DIR_DOWN = 1'b1;

    // Next index after one step. Arithmetic is against pos (the number of
    // positions), not the power of two the index width could reach.
    function automatic int seq_next_index(
        input int   idx,
        input logic dir,
        input int   pos,
        input bit   wrap_en
    );
        int result;
        result = idx;
        if (dir == DIR_UP) begin
            if (idx >= pos - 1) begin
                result = wrap_en ? 0 : pos - 1;
            end else begin
                result = idx + 1;
            end
        end else begin
            if (idx <= 0) begin
                result = wrap_en ? pos - 1 : 0;
            end else begin
                result = idx - 1;
            end
        end
        return result;
    endfunction

    // True when a step in direction dir would cross an end of the range,
    // whether that end wraps or saturates.
    function automatic bit seq_at_boundary(
        input int   idx,
        input logic dir,
        input int   pos
    );
        bit hit;
        if (dir == DIR_UP) begin
            hit = (idx >= pos - 1);
        end else begin
            hit = (idx <= 0);
        end
        return hit;
    endfunction

endpackage

// File: rtl/oh_sequencer_if.sv
// Control and result bundle of the positional sequencer. The master side
// issues load/step/mode controls; the slave side returns the registered
// index, decoded vector and event pulses.
interface oh_sequencer_if #(
    parameter int N   = 3,
    parameter int POS = 2 ** N
) ();

    logic           load;
    logic [N-1:0]   load_idx;
    logic           step;
    logic           dir;
    logic           mode;
    logic [N-1:0]   index;
    logic [POS-1:0] positional;
    logic           wrap;
    logic           err;

    modport master (
        output load,
        output load_idx,
        output step,
        output dir,
        output mode,
        input  index,
        input  positional,
        input  wrap,
        input  err
    );

    modport slave (
        input  load,
        input  load_idx,
        input  step,
        input  dir,
        input  mode,
        output index,
        output positional,
        output wrap,
        output err
    );

endinterface

// File: rtl/oh_sequencer_pos_decoder.sv
// Combinational binary-to-positional decoder. In one-hot mode exactly the
// bit at index is set; in thermometer mode every bit at or below index is set.
module pos_decoder
    import oh_sequencer_pkg::*;
#(
    parameter int N   = 3,
    parameter int POS = 2 ** N
) (
    input  logic [N-1:0]   index,
    input  logic           mode,
    output logic [POS-1:0] positional
);

    // One comparator per output position; positions beyond POS-1 do not exist,
    // so an index that could exceed them never has to be handled here.
    generate
        for (genvar gi = 0; gi < POS; gi++) begin : g_bit
            assign positional[gi] = (mode == MODE_THERM) ? (index >= N'(gi))
                                                         : (index == N'(gi));
        end
    endgenerate

endmodule

// File: rtl/oh_sequencer.sv
// Registered position sequencer: holds an index that is loaded or stepped
// (wrapping or saturating at the ends of a possibly non-power-of-2 range),
// and presents it alongside its registered one-hot or thermometer decode.
// Wrap/saturation and rejected-load events are flagged as one-cycle pulses.
module oh_sequencer
    import oh_sequencer_pkg::*;
#(
    parameter int N    = 3,
    parameter int POS  = 2 ** N,
    parameter int WRAP = 1
) (
    input  logic          clk,
    input  logic          rst_n,
    oh_sequencer_if.slave bus
);

    logic [N-1:0]   index_reg;
    logic [N-1:0]   index_next;
    logic [POS-1:0] positional_reg;
    logic [POS-1:0] positional_next;
    logic           wrap_reg;
    logic           wrap_next;
    logic           err_reg;
    logic           err_next;
    logic           load_legal;

    // A load is only accepted when it names an existing position.
    assign load_legal = (int'(bus.load_idx) < POS);

    // Next index and event pulses; load has priority over step, and an
    // illegal load holds the index rather than falling through to step.
    always_comb begin
        index_next = index_reg;
        wrap_next  = 1'b0;
        err_next   = 1'b0;
        if (bus.load) begin
            if (load_legal) begin
                index_next = bus.load_idx;
            end else begin
                err_next = 1'b1;
            end
        end else if (bus.step) begin
            index_next = N'(seq_next_index(int'(index_reg), bus.dir, POS, WRAP != 0));
            wrap_next  = seq_at_boundary(int'(index_reg), bus.dir, POS);
        end
    end

    // Decode from the next index so the registered vector always matches the
    // registered index; a mode change alone re-decodes on the next edge.
    pos_decoder #(
        .N   (N),
        .POS (POS)
    ) u_decoder (
        .index      (index_next),
        .mode       (bus.mode),
        .positional (positional_next)
    );

    // Output register; reset discards any load or step in the same cycle.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            index_reg      <= '0;
            positional_reg <= POS'(1);
            wrap_reg       <= 1'b0;
            err_reg        <= 1'b0;
        end else begin
            index_reg      <= index_next;
            positional_reg <= positional_next;
            wrap_reg       <= wrap_next;
            err_reg        <= err_next;
        end
    end

    assign bus.index      = index_reg;
    assign bus.positional = positional_reg;
    assign bus.wrap       = wrap_reg;
    assign bus.err        = err_reg;

endmodule

// File: tb/tb_oh_sequencer.sv
// Scoreboard bench for oh_sequencer. Two instances share one stimulus stream:
// a full-range wrapping one (POS=8, WRAP=1) and a short saturating one
// (POS=6, WRAP=0). The driver pushes model expectations; a monitor pops and
// compares one entry per clock edge.
module tb_oh_sequencer;

    typedef struct {
        int idx;
        int pos;
        bit wrap;
        bit err;
    } exp_t;

    logic clk;
    logic rst_n;

    oh_sequencer_if #(.N(3), .POS(8)) bus_a ();
    oh_sequencer_if #(.N(3), .POS(6)) bus_b ();

    oh_sequencer #(.N(3), .POS(8), .WRAP(1)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_a)
    );

    oh_sequencer #(.N(3), .POS(6), .WRAP(0)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_b)
    );

    exp_t q_a[$];
    exp_t q_b[$];
    int   cur_a = 0;
    int   cur_b = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    int   n_txn = 0;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference model: positions 0..np-1, modular wrap or clamping, and the
    // decoded vector as a power of two (one-hot) or 2^(i+1)-1 (thermometer).
    function automatic exp_t model(input int cur, input int np, input bit wr,
                                   input bit r, input bit ld, input int lidx,
                                   input bit st, input bit dr, input bit md);
        exp_t e;
        int   nxt;
        nxt    = cur;
        e.wrap = 1'b0;
        e.err  = 1'b0;
        e.idx  = 0;
        e.pos  = 1;
        if (!r) return e;
        if (ld) begin
            if (lidx < np) nxt = lidx;
            else e.err = 1'b1;
        end else if (st) begin
            if (!dr) begin
                e.wrap = (cur == np - 1);
                nxt = wr ? (cur + 1) % np : ((cur + 1 > np - 1) ? np - 1 : cur + 1);
            end else begin
                e.wrap = (cur == 0);
                nxt = wr ? (cur + np - 1) % np : ((cur == 0) ? 0 : cur - 1);
            end
        end
        e.idx = nxt;
        e.pos = md ? ((1 << (nxt + 1)) - 1) : (1 << nxt);
        return e;
    endfunction

    task automatic check(input string nm, input int act, input int expv);
        n_vec++;
        if (act != expv) begin
            n_miss++;
            $display("FAIL %s: got %0d, expected %0d (txn %0d)", nm, act, expv, n_txn);
        end
    endtask

    // Drive one cycle of controls to both instances and queue expectations.
    task automatic apply(input bit r, input bit ld, input int lidx,
                         input bit st, input bit dr, input bit md);
        exp_t ea;
        exp_t eb;
        @(negedge clk);
        rst_n          = r;
        bus_a.load     = ld;
        bus_a.load_idx = 3'(lidx);
        bus_a.step     = st;
        bus_a.dir      = dr;
        bus_a.mode     = md;
        bus_b.load     = ld;
        bus_b.load_idx = 3'(lidx);
        bus_b.step     = st;
        bus_b.dir      = dr;
        bus_b.mode     = md;
        ea = model(cur_a, 8, 1'b1, r, ld, lidx, st, dr, md);
        eb = model(cur_b, 6, 1'b0, r, ld, lidx, st, dr, md);
        cur_a = ea.idx;
        cur_b = eb.idx;
        q_a.push_back(ea);
        q_b.push_back(eb);
    endtask

    // Monitor: outputs are registered, so each queued expectation is due just
    // after the next rising edge.
    initial begin
        exp_t ea;
        exp_t eb;
        forever begin
            @(posedge clk);
            #1;
            if (q_a.size() != 0 && q_b.size() != 0) begin
                ea = q_a.pop_front();
                eb = q_b.pop_front();
                n_txn++;
                $display("txn %0d: a idx=%0d pos=%b wrap=%0b err=%0b | b idx=%0d pos=%b wrap=%0b err=%0b",
                         n_txn, bus_a.index, bus_a.positional, bus_a.wrap, bus_a.err,
                         bus_b.index, bus_b.positional, bus_b.wrap, bus_b.err);
                check("a_index", int'(bus_a.index), ea.idx);
                check("a_positional", int'(bus_a.positional), ea.pos);
                check("a_wrap", int'(bus_a.wrap), int'(ea.wrap));
                check("a_err", int'(bus_a.err), int'(ea.err));
                check("b_index", int'(bus_b.index), eb.idx);
                check("b_positional", int'(bus_b.positional), eb.pos);
                check("b_wrap", int'(bus_b.wrap), int'(eb.wrap));
                check("b_err", int'(bus_b.err), int'(eb.err));
            end
        end
    end

    initial begin
        rst_n = 1'b0;
        // Reset with arbitrary controls.
        apply(1'b0, 1'b1, 5, 1'b1, 1'b0, 1'b1);
        apply(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        // Load 5, one-hot.
        apply(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        // Load 7 (illegal for b), step up: a wraps to 0, b saturates.
        apply(1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        // Step down from 0: a wraps to 7, b goes 5->4.
        apply(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0);
        // b at 5 stepped up twice saturates; then illegal loads 6 and 7.
        apply(1'b1, 1'b1, 5, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 6, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b1, 7, 1'b0, 1'b0, 1'b0);
        // Index 3, mode change alone re-decodes.
        apply(1'b1, 1'b1, 3, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b0);
        apply(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        apply(1'b1, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        // Load beats step; reset beats both.
        apply(1'b1, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        apply(1'b0, 1'b1, 2, 1'b1, 1'b0, 1'b0);
        // Load sweep in both modes.
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < 8; i++) begin
                apply(1'b1, 1'b1, i, 1'b0, 1'b0, 1'(m));
            end
        end
        // Step 2*POS up, then down, crossing each end twice.
        apply(1'b1, 1'b1, 0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < 16; k++) apply(1'b1, 1'b0, 0, 1'b1, 1'b0, 1'(k % 2));
        for (int k = 0; k < 16; k++) apply(1'b1, 1'b0, 0, 1'b1, 1'b1, 1'(k % 2));
        // Random traffic.
        for (int k = 0; k < 300; k++) begin
            apply($urandom_range(0, 99) >= 3, $urandom_range(0, 99) < 30,
                  int'($urandom_range(0, 7)), $urandom_range(0, 99) < 60,
                  1'($urandom_range(0, 1)), $urandom_range(0, 99) < 20);
        end
        // Let the last expectations drain, bounded.
        repeat (3) @(posedge clk);
        #2;
        n_vec++;
        if (q_a.size() != 0 || q_b.size() != 0) begin
            n_miss++;
            $display("FAIL drain: %0d/%0d entries left, expected 0", q_a.size(), q_b.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
